// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end for a VLIW core. It streams 64-bit bundles from
// a synchronous-read RAM (one cycle of read latency) into a small FIFO. The
// decode stage drains the FIFO through a valid/ready handshake. The fetch
// address advances by 8 bytes per issued read.
//
// Reads are credit limited. A read issues only while the queued entries plus
// the single outstanding read are fewer than DEPTH. As a result, a returning
// read always finds a free slot. A redirect flushes the queue and drops any
// outstanding read, then restarts fetch at the 8-byte-aligned target.
//
// Parameters
//   DEPTH     number of 64-bit bundle entries (power of two, 2..16)
//   RESET_PC  byte address of the first fetch after reset
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-high reset
//   addressBus      RAM read byte address (always the registered fetch_pc)
//   dataIn          RAM read data, valid the cycle after addressBus
//   enableWrite     RAM write enable, constant 0
//   bundle          instruction bundle at the queue head
//   bundle_pc       byte address of the head bundle
//   bundle_valid    queue is non-empty
//   bundle_ready    consumer accepts the head this cycle
//   redirect_valid  single-cycle branch/redirect request
//   redirect_pc     redirect target byte address
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [55:0] RESET_PC = 56'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [55:0] addressBus,
  input  logic [63:0] dataIn,
  output logic        enableWrite,
  output logic [63:0] bundle,
  output logic [55:0] bundle_pc,
  output logic        bundle_valid,
  input  logic        bundle_ready,
  input  logic        redirect_valid,
  input  logic [55:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // Masking keeps fetch_pc 8-byte aligned even for a misaligned RESET_PC.
  localparam logic [55:0] ALIGN_MASK  = ~56'h7;
  localparam logic [55:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  logic [55:0]   fetch_pc_q,    fetch_pc_d;
  logic          inflight_q,    inflight_d;
  logic [55:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q,       count_d;
  logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,      rd_ptr_d;

  logic [63:0]   data_mem_q [DEPTH];
  logic [55:0]   pc_mem_q   [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;

  // Credit check: queued entries plus the outstanding read must leave a slot.
  assign issue = !redirect_valid && ((count_q + CW'(inflight_q)) < DEPTH_C);
  // The read issued last cycle returns now, unless a redirect discards it.
  assign push  = inflight_q && !redirect_valid;
  // The consumer owns the head once it handshakes, even in a redirect cycle.
  // The flush below overrides the pointer and count updates in that case.
  assign pop   = bundle_valid && bundle_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      inflight_d = 1'b0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 56'd8;
        inflight_pc_d = fetch_pc_q;
      end
      // The old read retires through push; a new issue takes its place.
      inflight_d = issue;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC_AL;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC_AL;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: the bundle storage has no reset. count_q gates its visibility, so
  // stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= dataIn;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign addressBus   = fetch_pc_q;
  assign enableWrite  = 1'b0;
  assign bundle_valid = (count_q != '0);
  // The head is read from registers, so there is no path from dataIn to bundle.
  assign bundle       = data_mem_q[rd_ptr_q];
  assign bundle_pc    = pc_mem_q[rd_ptr_q];

  // The credit rule makes a push into a full queue unreachable.
  no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(push && (count_q == DEPTH_C))
  );

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (DEPTH = 4, RESET_PC = 0).
//
// The bench has two parts:
//   - Cycle-exact vector tables for the steady-fetch and backpressure runs,
//     plus hand-written sequences for wrap, redirect and mid-stream reset.
//   - A randomized run checked by a stream-level model. After each redirect,
//     the consumer must see bundles at consecutive 8-byte addresses starting
//     at the aligned target, each carrying the RAM word for that address.
//
// The RAM model returns word[i] = i for byte address 8*i. In scrambled mode
// it returns a hashed value, so that every data bit is exercised.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [55:0] RESET_PC = 56'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] addressBus;
  logic [63:0] dataIn;
  logic        enableWrite;
  logic [63:0] bundle;
  logic [55:0] bundle_pc;
  logic        bundle_valid;
  logic        bundle_ready;
  logic        redirect_valid;
  logic [55:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;
  bit scramble = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .addressBus     (addressBus),
    .dataIn         (dataIn),
    .enableWrite    (enableWrite),
    .bundle         (bundle),
    .bundle_pc      (bundle_pc),
    .bundle_valid   (bundle_valid),
    .bundle_ready   (bundle_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ram_word(input logic [55:0] a);
    logic [63:0] idx;
    idx = {11'b0, a[55:3]};
    return scramble ? ((idx * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF) : idx;
  endfunction

  // Synchronous-read RAM with one cycle of latency.
  always @(posedge clk) dataIn <= ram_word(addressBus);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // The RAM write enable must stay low at all times.
  always @(negedge clk) check("enableWrite", {63'b0, enableWrite}, 64'd0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [55:0] exp_addr;
    logic [55:0] exp_pc;
    logic [63:0] exp_bundle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [55:0] a,
                              input logic [55:0] p, input logic [63:0] b);
    vec_t t;
    t.ready = r; t.exp_valid = v; t.exp_addr = a; t.exp_pc = p; t.exp_bundle = b;
    return t;
  endfunction

  // Wait one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [55:0] a,
                            input logic [55:0] p, input logic [63:0] b);
    check({tag, ".valid"}, {63'b0, bundle_valid}, {63'b0, v});
    check({tag, ".addr"}, {8'b0, addressBus}, {8'b0, a});
    if (v) begin
      check({tag, ".pc"}, {8'b0, bundle_pc}, {8'b0, p});
      check({tag, ".bundle"}, bundle, b);
    end
  endtask

  task automatic run_vectors(input string tag, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bundle_ready = vecs[i].ready;
      step();
      check_head($sformatf("%s[%0d]", tag, i - first), vecs[i].exp_valid,
                 vecs[i].exp_addr, vecs[i].exp_pc, vecs[i].exp_bundle);
    end
  endtask

  // Assert reset mid-cycle so the asynchronous clear is observable at once.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({tag, ".rst_valid"}, {63'b0, bundle_valid}, 64'd0);
    check({tag, ".rst_addr"}, {8'b0, addressBus}, {8'b0, RESET_PC});
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".rst_hold_addr"}, {8'b0, addressBus}, {8'b0, RESET_PC});
    rst = 1'b0;
  endtask

  logic [55:0] exp_pc;
  logic [55:0] last_target;
  logic [63:0] rnd;
  bit          have_exp;
  bit          last_redir;
  int          got;

  initial begin
    rst            = 1'b1;
    bundle_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Steady fetch: one issue per cycle, first bundle two edges after issue.
    vecs.push_back(mk(1'b1, 1'b0, 56'h8, 56'h0, 64'h0));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(1'b1, 1'b1, 56'(8 * (k + 1)), 56'(8 * (k - 1)), 64'(k - 1)));
    // Backpressure (rows 8..22): four entries fill the queue, fetch parks at 0x20.
    vecs.push_back(mk(1'b0, 1'b0, 56'h8, 56'h0, 64'h0));
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk(1'b0, 1'b1, 56'(8 * (k + 1)), 56'h0, 64'h0));
    for (int k = 4; k <= 9; k++)
      vecs.push_back(mk(1'b0, 1'b1, 56'h20, 56'h0, 64'h0));
    // Ready released: the queue drains in order, fetch resumes with credit.
    vecs.push_back(mk(1'b1, 1'b1, 56'h20, 56'h08, 64'd1));
    vecs.push_back(mk(1'b1, 1'b1, 56'h28, 56'h10, 64'd2));
    vecs.push_back(mk(1'b1, 1'b1, 56'h30, 56'h18, 64'd3));
    vecs.push_back(mk(1'b1, 1'b1, 56'h38, 56'h20, 64'd4));
    vecs.push_back(mk(1'b1, 1'b1, 56'h40, 56'h28, 64'd5));

    pulse_reset("init");
    run_vectors("steady", 0, 7);

    // Wrap: redirect to the top bundle address; fetch wraps to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 56'hFF_FFFF_FFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    check_head("wrap0", 1'b0, 56'hFF_FFFF_FFFF_FFF8, 56'h0, 64'h0);
    step();
    check_head("wrap1", 1'b0, 56'h0, 56'h0, 64'h0);
    step();
    check_head("wrap2", 1'b1, 56'h8, 56'hFF_FFFF_FFFF_FFF8, 64'h001F_FFFF_FFFF_FFFF);
    step();
    check_head("wrap3", 1'b1, 56'h10, 56'h0, 64'h0);
    step();
    check_head("wrap4", 1'b1, 56'h18, 56'h8, 64'h1);

    // Mid-stream reset, then backpressure from RESET_PC.
    pulse_reset("midrst");
    run_vectors("bp", 8, 22);

    // Redirect with three entries queued and one read outstanding.
    pulse_reset("rdrst");
    bundle_ready = 1'b0;
    repeat (4) step();
    check_head("rd_pre", 1'b1, 56'h20, 56'h0, 64'h0);
    bundle_ready   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 56'h1003;
    step();
    redirect_valid = 1'b0;
    check_head("rd0", 1'b0, 56'h1000, 56'h0, 64'h0);
    step();
    check_head("rd1", 1'b0, 56'h1008, 56'h0, 64'h0);
    step();
    check_head("rd2", 1'b1, 56'h1010, 56'h1000, 64'h200);
    step();
    check_head("rd3", 1'b1, 56'h1018, 56'h1008, 64'h201);

    // Randomized run against the stream model.
    scramble   = 1'b1;
    have_exp   = 1'b0;
    last_redir = 1'b0;
    exp_pc     = '0;
    for (int i = 0; i < 2000; i++) begin
      if (last_redir) begin
        check("rand.redir_valid", {63'b0, bundle_valid}, 64'd0);
        check("rand.redir_addr", {8'b0, addressBus}, {8'b0, last_target});
      end
      check("rand.addr_align", {61'b0, addressBus[2:0]}, 64'd0);
      bundle_ready   = ($urandom_range(0, 99) < 70);
      redirect_valid = (i == 0) || ($urandom_range(0, 99) < 4);
      rnd            = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rnd[55:8] = '1;
      redirect_pc = rnd[55:0];
      if (bundle_valid && bundle_ready && have_exp) begin
        check("rand.pc", {8'b0, bundle_pc}, {8'b0, exp_pc});
        check("rand.bundle", bundle, ram_word(exp_pc));
        exp_pc = exp_pc + 56'd8;
      end
      if (redirect_valid) begin
        exp_pc   = {redirect_pc[55:3], 3'b000};
        have_exp = 1'b1;
      end
      last_redir  = redirect_valid;
      last_target = {redirect_pc[55:3], 3'b000};
      step();
    end

    // Drain: with ready held high, delivery must settle to one bundle per cycle.
    redirect_valid = 1'b0;
    bundle_ready   = 1'b1;
    if (last_redir) begin
      check("drain.redir_valid", {63'b0, bundle_valid}, 64'd0);
      check("drain.redir_addr", {8'b0, addressBus}, {8'b0, last_target});
    end
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (bundle_valid) begin
        check("drain.pc", {8'b0, bundle_pc}, {8'b0, exp_pc});
        check("drain.bundle", bundle, ram_word(exp_pc));
        exp_pc = exp_pc + 56'd8;
        got++;
      end
      step();
    end
    check("drain.throughput", {63'b0, (got >= 8)}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 64-bit bundle entries in the queue (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 56'h0, meaning the byte address of the first fetch after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port addressBus, output, 56, the byte address of the memory read, driven to the ram.
REQ-006 SHALL have port dataIn, input, 64, the read data returned by the ram.
REQ-007 SHALL have port enableWrite, output, 1, the ram write enable, held constant 0.
REQ-008 SHALL have port bundle, output, 64, the instruction bundle at the head of the queue.
REQ-009 SHALL have port bundle_pc, output, 56, the byte address of the head bundle.
REQ-010 SHALL have port bundle_valid, output, 1, asserted when the queue is non-empty.
REQ-011 SHALL have port bundle_ready, input, 1, the consumer (vliw decode) accepts the head this cycle.
REQ-012 SHALL have port redirect_valid, input, 1, a single-cycle branch/redirect request.
REQ-013 SHALL have port redirect_pc, input, 56, the redirect target byte address.

Function
REQ-014 SHALL treat the ram as a synchronous read: dataIn is valid the cycle after addressBus is presented (latency 1).
REQ-015 SHALL hold a registered fetch_pc, drive addressBus = fetch_pc, and keep fetch_pc 8-byte aligned (bits [2:0] always 0).
REQ-016 SHALL issue a read in a cycle when (count + inflight) < DEPTH and redirect_valid = 0; on issue, fetch_pc <= fetch_pc + 8 (mod 2^56) and inflight <= 1 with inflight_pc <= fetch_pc.
REQ-017 SHALL, in a cycle with inflight = 1 and no redirect, push {dataIn, inflight_pc} into the queue tail; inflight clears unless a new read issues the same cycle.
REQ-018 SHALL pop the head when bundle_valid & bundle_ready; push and pop in the same cycle SHALL leave count unchanged, including when count = DEPTH.
REQ-019 SHALL never push while full; the credit rule in REQ-016 guarantees this, and an assertion SHALL flag a violation.
REQ-020 SHALL present bundle and bundle_pc from registered storage (no combinational path from dataIn to bundle), so a fetched word is visible at the head no earlier than 2 cycles after its address.
REQ-021 SHALL, on redirect_valid = 1, clear the queue (count <= 0, pointers reset), discard any inflight read, set fetch_pc <= {redirect_pc[55:3], 3'b000}, and issue nothing that cycle.
REQ-022 SHALL give redirect priority over simultaneous push, pop and issue; a pop handshake in the redirect cycle is still considered consumed by the consumer.
REQ-023 SHALL keep the read/write pointers as log2(DEPTH)-bit wrapping counters and count as log2(DEPTH)+1 bits.
REQ-024 SHALL, when bundle_valid = 0, drive bundle and bundle_pc as don't-care; the bench SHALL NOT check them then.
REQ-025 SHALL wrap fetch_pc from 56'hFF_FFFF_FFFF_FFF8 to 0 without error.

Reset
REQ-026 SHALL, while rst = 1, force fetch_pc = RESET_PC, count = 0, inflight = 0, pointers = 0, bundle_valid = 0, enableWrite = 0, addressBus = RESET_PC.
REQ-027 SHALL, after rst deasserts, issue the first read on the first rising edge of clk.
REQ-028 SHALL, when rst asserts mid-operation, abandon all queued and inflight data immediately and asynchronously.

Verification
REQ-029 SHALL test reset then steady fetch: RESET_PC = 0, bundle_ready = 1, ram preloaded word[i] = i -> bundle_pc sequence 0, 8, 16, ... with bundle = 0, 1, 2, ...; first bundle_valid 2 cycles after the first issue; one bundle per cycle thereafter.
REQ-030 SHALL test backpressure: bundle_ready = 0 for 10 cycles -> count saturates at 4, addressBus stops advancing at 0x20, no entry is lost; releasing ready -> bundles at 0x00..0x18 delivered in order.
REQ-031 SHALL test redirect: redirect to 0x1003 while full with a read inflight -> bundle_valid = 0 the next cycle, next addressBus = 0x1000, first post-redirect bundle_pc = 0x1000, no stale bundle observed.
REQ-032 SHALL test simultaneous push and pop while full -> count stays 4 and order is preserved.
REQ-033 SHALL test wrap: redirect to 56'hFF_FFFF_FFFF_FFF8 -> bundle_pc sequence FF..F8 then 0x0.
REQ-034 SHALL test mid-stream reset: rst pulsed for 3 cycles during fetch -> bundle_valid = 0 immediately and fetch resumes at RESET_PC; enableWrite = 0 throughout all tests.
